// File: rtl/door_pkg.sv
// Shared definitions for the door controller: state encoding and default sizing.
package door_pkg;

    // Door FSM state encoding; also driven out on the debug state port.
    typedef enum logic [1:0] {
        CLOSED  = 2'b00,
        OPENING = 2'b01,
        OPEN    = 2'b10,
        CLOSING = 2'b11
    } door_state_t;

    // Full door travel is 1 s at the 50 Hz tick.
    localparam int unsigned DEF_TRAVEL_TICKS = 50;

    // Travel counter width; must satisfy 2**DEF_CNT_W > DEF_TRAVEL_TICKS.
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/edge_det.sv
// Registered edge detector: delays the input one clock and flags either a
// rising or a falling transition, selected by the Rising parameter.
module edge_det #(
    parameter bit Rising = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Previous-cycle copy of the input, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    // Edge pulse from the current input against its registered copy.
    always_comb begin
        pulse = Rising ? (d & ~d_q) : (d_q & ~d);
    end

endmodule

// File: rtl/door_ctrl.sv
// Door controller FSM, downstream of the 2 s door-wait timer.
// Optional feature macro: DOOR_OBSTRUCT_EN (obstruction sensor reopens the
// closing door and holds the dwell timer cleared while open).
module door_ctrl
    import door_pkg::*;
#(
    parameter int unsigned TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arr,
    input  logic       open_btn,
    input  logic       close_btn,
    input  logic       obstruct,
    input  logic       wait_c100,
    output logic       wait_run,
    output logic       door_open_cmd,
    output logic       door_close_cmd,
    output logic       door_closed,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] TravelLoad = CNT_W'(TRAVEL_TICKS - 1);

    door_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arr_rise;
    logic             c100_fall;
    logic             reopen;
    logic             hold_clear;

    edge_det #(
        .Rising(1'b1)
    ) u_arr_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (arr),
        .pulse(arr_rise)
    );

    edge_det #(
        .Rising(1'b0)
    ) u_c100_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (wait_c100),
        .pulse(c100_fall)
    );

`ifdef DOOR_OBSTRUCT_EN
    assign reopen     = open_btn | obstruct;
    assign hold_clear = open_btn | obstruct;
`else
    // Sensor is not part of this build; keep it visibly unused.
    logic unused_obstruct;
    assign unused_obstruct = obstruct;
    assign reopen          = open_btn;
    assign hold_clear      = open_btn;
`endif

    // State and travel counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLOSED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update; the counter only loads on a leg start
    // and otherwise counts down to 0 and stays there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLOSED: begin
                if (arr_rise || (arr && open_btn)) begin
                    state_d = OPENING;
                    cnt_d   = TravelLoad;
                end
            end
            OPENING: begin
                if (cnt_q == '0) begin
                    state_d = OPEN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OPEN: begin
                if (!open_btn && (c100_fall || close_btn)) begin
                    state_d = CLOSING;
                    cnt_d   = TravelLoad;
                end
            end
            CLOSING: begin
                if (reopen) begin
                    // Reverse travel equals the distance already closed.
                    state_d = OPENING;
                    cnt_d   = TravelLoad - cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = CLOSED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = CLOSED;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs from the state register; wait_run also sees the button.
    always_comb begin
        door_closed    = (state_q == CLOSED);
        door_open_cmd  = (state_q == OPENING);
        door_close_cmd = (state_q == CLOSING);
        wait_run       = (state_q == OPEN) && !hold_clear;
        state          = state_q;
    end

endmodule

// File: tb/tb_door_ctrl.sv
// Self-checking bench for door_ctrl: directed scenarios followed by random
// stimulus, all checked each cycle against a door travel model.
module tb_door_ctrl;

    localparam int T = 4;
    localparam logic [1:0] S_CLOSED  = 2'b00;
    localparam logic [1:0] S_OPENING = 2'b01;
    localparam logic [1:0] S_OPEN    = 2'b10;
    localparam logic [1:0] S_CLOSING = 2'b11;

`ifdef DOOR_OBSTRUCT_EN
    localparam bit ObstructEn = 1'b1;
`else
    localparam bit ObstructEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       arr, open_btn, close_btn, obstruct, wait_c100;
    logic       wait_run, door_open_cmd, door_close_cmd, door_closed;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Model: door phase plus progress through the current travel leg.
    logic [1:0] m_ph;
    int         m_elapsed;
    int         m_leg_len;
    bit         m_arr_d, m_c100_d;

    door_ctrl #(
        .TRAVEL_TICKS(T),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arr           (arr),
        .open_btn      (open_btn),
        .close_btn     (close_btn),
        .obstruct      (obstruct),
        .wait_c100     (wait_c100),
        .wait_run      (wait_run),
        .door_open_cmd (door_open_cmd),
        .door_close_cmd(door_close_cmd),
        .door_closed   (door_closed),
        .state         (state)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph      = S_CLOSED;
        m_elapsed = 0;
        m_leg_len = 0;
        m_arr_d   = 1'b0;
        m_c100_d  = 1'b0;
    endtask

    task automatic compare_outputs();
        bit exp_wr;
        exp_wr = (m_ph == S_OPEN) && !open_btn && !(ObstructEn && obstruct);
        check("state", 8'(state), 8'(m_ph));
        check("door_closed", 8'(door_closed), 8'(m_ph == S_CLOSED));
        check("door_open_cmd", 8'(door_open_cmd), 8'(m_ph == S_OPENING));
        check("door_close_cmd", 8'(door_close_cmd), 8'(m_ph == S_CLOSING));
        check("wait_run", 8'(wait_run), 8'(exp_wr));
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        bit arr_rise, c100_fall, reopen;
        if (rst) begin
            model_reset();
            return;
        end
        arr_rise  = arr && !m_arr_d;
        c100_fall = m_c100_d && !wait_c100;
        reopen    = open_btn || (ObstructEn && obstruct);
        case (m_ph)
            S_CLOSED: begin
                if (arr_rise || (arr && open_btn)) begin
                    m_ph = S_OPENING; m_elapsed = 0; m_leg_len = T;
                end
            end
            S_OPENING: begin
                if (m_elapsed + 1 == m_leg_len) m_ph = S_OPEN;
                else m_elapsed++;
            end
            S_OPEN: begin
                if (!open_btn && (c100_fall || close_btn)) begin
                    m_ph = S_CLOSING; m_elapsed = 0; m_leg_len = T;
                end
            end
            default: begin
                if (reopen) begin
                    // Reopening takes as long as the closing travel so far.
                    m_ph = S_OPENING; m_leg_len = m_elapsed + 1; m_elapsed = 0;
                end else if (m_elapsed + 1 == m_leg_len) begin
                    m_ph = S_CLOSED;
                end else begin
                    m_elapsed++;
                end
            end
        endcase
        m_arr_d  = arr;
        m_c100_d = wait_c100;
    endtask

    // Inputs are set at the falling edge; check, clock, update model.
    task automatic tick();
        #1;
        compare_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        open_btn  = 1'b0;
        close_btn = 1'b0;
        obstruct  = 1'b0;
    endtask

    // Tick until the model reaches the wanted phase, within a cycle budget.
    task automatic run_until(input logic [1:0] ph, input string tag);
        int budget;
        budget = 200;
        while (m_ph != ph && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_reached"}, 8'(m_ph == ph), 8'd1);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        arr = 1'b0;
        wait_c100 = 1'b0;
        idle_inputs();
        @(negedge clk);
        run(2);
        rst = 1'b0;

        // Arrival rising edge opens the door; dwell ends on carry falling.
        run(7);
        arr = 1'b1;
        run(T + 3);
        check("opened_after_arrival", 8'(state), 8'(S_OPEN));
        wait_c100 = 1'b1;
        run(3);
        wait_c100 = 1'b0;
        run(1);
        run_until(S_CLOSED, "dwell_close");
        run(3);

        // Reopen via new arrival, then hold open through a carry fall.
        arr = 1'b0;
        run(2);
        arr = 1'b1;
        run_until(S_OPEN, "reopen");
        wait_c100 = 1'b1;
        open_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) wait_c100 = 1'b0;
            tick();
        end
        check("held_open", 8'(state), 8'(S_OPEN));

        // Both buttons: open wins; then close alone starts closing.
        open_btn = 1'b1;
        close_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        tick();
        close_btn = 1'b0;
        check("close_btn_closing", 8'(state), 8'(S_CLOSING));

        // Reopen partway through closing, then close again.
        run(2);
        open_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        run_until(S_OPEN, "partial_reopen");
        close_btn = 1'b1;
        tick();
        close_btn = 1'b0;
        run(1);
        obstruct = 1'b1;
        tick();
        obstruct = 1'b0;
        run(2 * T + 2);

        // Asynchronous reset mid-opening.
        arr = 1'b0;
        run_until(S_CLOSED, "pre_reset_closed");
        tick();
        arr = 1'b1;
        run(3);
        check("mid_opening", 8'(state), 8'(S_OPENING));
        rst = 1'b1;
        #1;
        check("rst_async_state", 8'(state), 8'(S_CLOSED));
        check("rst_async_open_cmd", 8'(door_open_cmd), 8'd0);
        check("rst_async_closed", 8'(door_closed), 8'd1);
        model_reset();
        run(2);
        rst = 1'b0;
        run(2);

        // Random stimulus.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) arr = ~arr;
            if ($urandom_range(5) == 0) wait_c100 = ~wait_c100;
            open_btn  = ($urandom_range(15) == 0);
            close_btn = ($urandom_range(9) == 0);
            obstruct  = ($urandom_range(19) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
